// File: rtl/bus_pkg.sv
// Shared types and constants for the memory bus controller.
//   bus_state_t  : controller FSM states (IDLE accepts address phases, WAIT stalls a read)
//   reg_idx_t    : decoded region index; UNMAPPED marks an address that hit no region
//   MAX_REG      : upper bound on the number of decoded regions
//   DEFAULT_FILL : read data returned for unmapped addresses
package bus_pkg;

    localparam int MAX_REG   = 8;
    localparam int REG_IDX_W = $clog2(MAX_REG) + 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // All-ones can never be a real region index because MAX_REG fits in one bit less.
    localparam reg_idx_t UNMAPPED = '1;

    localparam logic [7:0] DEFAULT_FILL = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side and device-side signals of the memory bus controller.
//   cpu_ab/cpu_do/cpu_we : CPU address, write data, write strobe
//   cpu_di/cpu_rdy       : read data and ready back to the CPU
//   dev_*                : region selects, write enable, address, write/read data
//   bus_err/err_count    : error pulse and saturating error counter
// Modport slave is the controller's view; master is the CPU/device-model view.
interface mem_bus_ctrl_if #(
    parameter int NREG = 3,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    logic [AW-1:0]      cpu_ab;
    logic [DW-1:0]      cpu_do;
    logic               cpu_we;
    logic [DW-1:0]      cpu_di;
    logic               cpu_rdy;
    logic [NREG-1:0]    dev_sel;
    logic               dev_we;
    logic [AW-1:0]      dev_addr;
    logic [DW-1:0]      dev_wdata;
    logic [NREG*DW-1:0] dev_rdata;
    logic               bus_err;
    logic [7:0]         err_count;

    modport slave (
        input  cpu_ab, cpu_do, cpu_we, dev_rdata,
        output cpu_di, cpu_rdy, dev_sel, dev_we, dev_addr, dev_wdata, bus_err, err_count
    );

    modport master (
        output cpu_ab, cpu_do, cpu_we, dev_rdata,
        input  cpu_di, cpu_rdy, dev_sel, dev_we, dev_addr, dev_wdata, bus_err, err_count
    );
endinterface

// File: rtl/bus_region_decode.sv
// Combinational priority address decoder.
//   addr : address to decode
//   idx  : lowest region index whose masked address equals its base, else UNMAPPED
//   hit  : high when any region matched
module bus_region_decode import bus_pkg::*; #(
    parameter int            NREG               = 3,
    parameter int            AW                 = 16,
    parameter logic [AW-1:0] REG_BASE [NREG]    = '{16'h0000, 16'h8000, 16'hC000},
    parameter logic [AW-1:0] REG_MASK [NREG]    = '{16'h8000, 16'hC000, 16'hF000}
) (
    input  logic [AW-1:0] addr,
    output reg_idx_t      idx,
    output logic          hit
);

    // Walking from the highest index down lets the lowest matching index win.
    always_comb begin
        idx = UNMAPPED;
        hit = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((addr & REG_MASK[i]) == REG_BASE[i]) begin
                idx = reg_idx_t'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes the CPU address into one of NREG regions,
// stalls reads for the region's latency, returns read data (or FILL when
// unmapped), blocks writes to read-only regions and counts bus errors.
//   clk   : sole clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : mem_bus_ctrl_if.slave carrying the CPU and device signals
module mem_bus_ctrl import bus_pkg::*; #(
    parameter int            NREG            = 3,
    parameter int            AW              = 16,
    parameter int            DW              = 8,
    parameter logic [AW-1:0] REG_BASE [NREG] = '{16'h0000, 16'h8000, 16'hC000},
    parameter logic [AW-1:0] REG_MASK [NREG] = '{16'h8000, 16'hC000, 16'hF000},
    parameter int            REG_LAT  [NREG] = '{1, 2, 3},
    parameter logic [NREG-1:0] REG_RO        = 3'b010,
    parameter logic [DW-1:0] FILL            = DEFAULT_FILL
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus
);

    bus_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    reg_idx_t   sel_q;
    reg_idx_t   dec_idx;
    logic       dec_hit;
    logic [3:0] dec_lat;
    logic       dec_ro;
    logic       err_n;
    logic       cpu_rdy_q;
    logic       bus_err_q;
    logic [7:0] err_count_q;

    bus_region_decode #(
        .NREG     (NREG),
        .AW       (AW),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK)
    ) u_decode (
        .addr (bus.cpu_ab),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    // Per-region attributes of the currently decoded address.
    always_comb begin
        dec_lat = 4'd1;
        dec_ro  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (dec_hit && dec_idx == reg_idx_t'(i)) begin
                dec_lat = 4'(REG_LAT[i]);
                dec_ro  = REG_RO[i];
            end
        end
    end

    // Next state: only IDLE looks at the decode; WAIT just counts down.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 4'd0;
                if (!dec_hit) begin
                    err_n = 1'b1;
                end else if (bus.cpu_we && dec_ro) begin
                    err_n = 1'b1;
                end else if (!bus.cpu_we && dec_lat > 4'd1) begin
                    state_n = WAIT;
                    cnt_n   = dec_lat - 4'd1;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Registered stage: FSM, ready, latched region, error pulse and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cpu_rdy_q   <= 1'b1;
            sel_q       <= UNMAPPED;
            bus_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cpu_rdy_q <= (state_n == IDLE);
            bus_err_q <= err_n;
            if (state == IDLE) begin
                sel_q <= dec_idx;
            end
            if (err_n && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Combinational outputs: read mux from the latched region, selects and write enable.
    always_comb begin
        bus.cpu_di  = FILL;
        bus.dev_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_q == reg_idx_t'(i)) begin
                bus.cpu_di = bus.dev_rdata[i*DW +: DW];
            end
            if (!reset) begin
                if (state == IDLE) begin
                    if (dec_hit && dec_idx == reg_idx_t'(i)) begin
                        bus.dev_sel[i] = 1'b1;
                    end
                end else if (sel_q == reg_idx_t'(i)) begin
                    bus.dev_sel[i] = 1'b1;
                end
            end
        end
    end

    assign bus.dev_we    = !reset && (state == IDLE) && dec_hit && !dec_ro && bus.cpu_we;
    assign bus.dev_addr  = bus.cpu_ab;
    assign bus.dev_wdata = bus.cpu_do;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

    logic clk;
    logic reset;

    mem_bus_ctrl_if #(.NREG(3), .AW(16), .DW(8)) bus ();

    mem_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] di;
        logic       err;
        int         stall;
        logic [2:0] sel;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] model_err = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference map written as plain address ranges.
    function automatic int ref_region(input logic [15:0] a);
        if (!a[15])                 return 0;
        if (a[15:14] == 2'b10)      return 1;
        if (a[15:12] == 4'hC)       return 2;
        return -1;
    endfunction

    function automatic logic [7:0] ref_data(input int r);
        logic [23:0] rd;
        rd = bus.dev_rdata;
        if (r < 0) return 8'hFF;
        return rd[r*8 +: 8];
    endfunction

    // Entered #1 after a posedge with the controller idle; leaves in the same phase.
    task automatic access(input string tag, input logic [15:0] a, input logic [7:0] d, input logic we);
        int   r;
        int   stalls;
        exp_t e;
        logic exp_we;
        r = ref_region(a);
        bus.cpu_ab = a;
        bus.cpu_do = d;
        bus.cpu_we = we;
        e.di    = ref_data(r);
        e.err   = (r < 0) || (we && r == 1);
        e.stall = (!we && r >= 0) ? r : 0;
        e.sel   = (r < 0) ? 3'b000 : 3'(1 << r);
        exp_we  = we && r >= 0 && r != 1;
        if (e.err && model_err != 8'hFF) model_err = model_err + 8'd1;
        e.cnt   = model_err;
        sb.push_back(e);

        @(negedge clk);
        chk({tag, ".dev_sel"}, 32'(bus.dev_sel), 32'(e.sel));
        chk({tag, ".dev_we"}, 32'(bus.dev_we), 32'(exp_we));
        chk({tag, ".dev_addr"}, 32'(bus.dev_addr), 32'(a));
        chk({tag, ".dev_wdata"}, 32'(bus.dev_wdata), 32'(d));

        @(posedge clk); #1;
        stalls = 0;
        while (bus.cpu_rdy !== 1'b1 && stalls < 16) begin
            stalls++;
            chk({tag, ".sel_hold"}, 32'(bus.dev_sel), 32'(e.sel));
            @(posedge clk); #1;
        end

        e = sb.pop_front();
        chk({tag, ".stall"}, 32'(stalls), 32'(e.stall));
        chk({tag, ".cpu_di"}, 32'(bus.cpu_di), 32'(e.di));
        chk({tag, ".bus_err"}, 32'(bus.bus_err), 32'(e.err));
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'(e.cnt));

        bus.cpu_ab = 16'h0000;
        bus.cpu_do = 8'h00;
        bus.cpu_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.cpu_ab    = 16'h0000;
        bus.cpu_do    = 8'h33;
        bus.cpu_we    = 1'b1;
        bus.dev_rdata = {8'h3C, 8'h96, 8'hA5};

        // Reset state; a write to region 0 is presented to prove dev_we stays low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cpu_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("rst.cpu_di", 32'(bus.cpu_di), 32'hFF);
        chk("rst.bus_err", 32'(bus.bus_err), 32'h0);
        chk("rst.err_count", 32'(bus.err_count), 32'h0);
        chk("rst.dev_sel", 32'(bus.dev_sel), 32'h0);
        chk("rst.dev_we", 32'(bus.dev_we), 32'h0);
        reset      = 1'b0;
        bus.cpu_we = 1'b0;
        @(posedge clk); #1;

        access("rd_r0", 16'h1234, 8'h00, 1'b0);
        access("rd_r1", 16'h8000, 8'h00, 1'b0);
        access("rd_r2", 16'hC010, 8'h00, 1'b0);
        access("wr_ro", 16'h9000, 8'h5A, 1'b1);
        access("rd_unm", 16'hE000, 8'h00, 1'b0);
        access("wr_r0", 16'h0040, 8'hC3, 1'b1);
        access("wr_r2", 16'hC123, 8'h7E, 1'b1);
        bus.dev_rdata = {8'h81, 8'h42, 8'h18};
        access("rd_r0_top", 16'h7FFF, 8'h00, 1'b0);
        access("rd_r1_top", 16'hBFFF, 8'h00, 1'b0);
        access("rd_r2_top", 16'hCFFF, 8'h00, 1'b0);
        access("rd_d000", 16'hD000, 8'h00, 1'b0);
        access("wr_unm", 16'hF00F, 8'h11, 1'b1);

        // Reset during the second WAIT cycle of a latency-3 read.
        bus.cpu_ab = 16'hC010;
        bus.cpu_we = 1'b0;
        @(posedge clk); #1;
        chk("rw.wait1_rdy", 32'(bus.cpu_rdy), 32'h0);
        @(posedge clk); #1;
        chk("rw.wait2_rdy", 32'(bus.cpu_rdy), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rw.sel_in_rst", 32'(bus.dev_sel), 32'h0);
        @(posedge clk); #1;
        chk("rw.cpu_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("rw.bus_err", 32'(bus.bus_err), 32'h0);
        chk("rw.err_count", 32'(bus.err_count), 32'h0);
        chk("rw.cpu_di", 32'(bus.cpu_di), 32'hFF);
        model_err  = 8'd0;
        reset      = 1'b0;
        bus.cpu_ab = 16'h0000;
        @(posedge clk); #1;
        chk("rw.after_rdy", 32'(bus.cpu_rdy), 32'h1);
        chk("rw.after_di", 32'(bus.cpu_di), 32'h18);

        // Saturation of the error counter.
        for (int k = 0; k < 300; k++) begin
            access("sat", 16'hE000 + 16'(k), 8'(k), k[0]);
        end
        chk("sat.count", 32'(bus.err_count), 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat.hold", 32'(bus.err_count), 32'hFF);
        chk("sat.err_idle", 32'(bus.bus_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 3: number of decoded regions, range 1..8.
REQ-002 SHALL have parameter AW, default 16: address width.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter REG_BASE[NREG], default {16'h0000,16'h8000,16'hC000}: region base addresses.
REQ-005 SHALL have parameter REG_MASK[NREG], default {16'h8000,16'hC000,16'hF000}: region compare masks.
REQ-006 SHALL have parameter REG_LAT[NREG], default {1,2,3}: read latency in cycles, range 1..8.
REQ-007 SHALL have parameter REG_RO, NREG bits, default 3'b010: per-region read-only flags.
REQ-008 SHALL have parameter FILL, default 8'hFF: read data returned for unmapped addresses.
REQ-009 SHALL have port clk  in  1: sole clock; all logic on posedge.
REQ-010 SHALL have port reset  in  1: synchronous reset, active-high.
REQ-011 SHALL have port cpu_ab  in  AW: CPU address.
REQ-012 SHALL have port cpu_do  in  DW: CPU write data.
REQ-013 SHALL have port cpu_we  in  1: CPU write strobe.
REQ-014 SHALL have port cpu_di  out  DW: read data to CPU.
REQ-015 SHALL have port cpu_rdy  out  1: CPU ready; while low the CPU holds cpu_ab, cpu_do and cpu_we.
REQ-016 SHALL have port dev_sel  out  NREG: one-hot region select.
REQ-017 SHALL have port dev_we  out  1: device write enable.
REQ-018 SHALL have port dev_addr  out  AW: device address (cpu_ab passed through).
REQ-019 SHALL have port dev_wdata  out  DW: device write data (cpu_do passed through).
REQ-020 SHALL have port dev_rdata  in  NREG*DW: device read data; region i occupies slice [i*DW +: DW].
REQ-021 SHALL have port bus_err  out  1: one-cycle error pulse.
REQ-022 SHALL have port err_count  out  8: saturating error counter.

Function
REQ-023 SHALL decode the region as the lowest index i with (cpu_ab & REG_MASK[i]) == REG_BASE[i]; if no index matches, the access SHALL be unmapped.
REQ-024 SHALL implement FSM states IDLE and WAIT: IDLE→WAIT on an accepted read of region i with REG_LAT[i]>1, loading cnt=REG_LAT[i]-1; WAIT decrements cnt each cycle; WAIT→IDLE when cnt==1.
REQ-025 SHALL accept an address phase in every IDLE cycle and SHALL NOT re-decode while in WAIT.
REQ-026 SHALL register cpu_rdy, driving it low for exactly REG_LAT[i]-1 cycles after the address phase; latency-1 reads, writes and unmapped accesses SHALL NOT stall.
REQ-027 SHALL latch the region index into sel_q at each accepted address phase.
REQ-028 SHALL drive cpu_di combinationally: dev_rdata slice sel_q, or FILL when sel_q is unmapped; cpu_di is valid in the first cpu_rdy-high cycle after the address phase.
REQ-029 SHALL drive dev_sel combinationally from the decode in IDLE and from sel_q in WAIT, keeping it one-hot or zero.
REQ-030 SHALL assert dev_we = cpu_we for a mapped non-RO region in an IDLE cycle only.
REQ-031 SHALL, on a write to an RO region, suppress dev_we and pulse bus_err for one cycle.
REQ-032 SHALL, on an unmapped read or write, pulse bus_err for one cycle.
REQ-033 SHALL increment err_count on each bus_err pulse, saturating at 8'hFF.

Reset
REQ-034 SHALL, on reset, set state=IDLE, cnt=0, cpu_rdy=1, sel_q=unmapped (so cpu_di=FILL), bus_err=0, err_count=0; dev_we=0 and dev_sel=0 while reset is high.
REQ-035 SHALL, on reset asserted in WAIT, abort the read with cpu_rdy=1 on the next cycle and no bus_err.

Structure
REQ-036 SHALL place the state enum, the region-index type (including the UNMAPPED code), MAX_REG=8 and the default FILL in the shared package bus_pkg.
REQ-037 SHALL place the priority decode in a combinational sub-module bus_region_decode, instantiated once.

Verification
REQ-038 SHALL verify: read 16'h1234 (region 0, L=1) with dev_rdata[7:0]=8'hA5 → cpu_rdy never low, cpu_di=8'hA5 in the next cycle.
REQ-039 SHALL verify: read 16'h8000 (region 1, L=2) → cpu_rdy low for 1 cycle, dev_sel=3'b010 held, then cpu_di=region 1 data.
REQ-040 SHALL verify: read 16'hC010 (region 2, L=3) with reset asserted in the second WAIT cycle → IDLE, cpu_rdy=1, err_count=0.
REQ-041 SHALL verify: write 8'h5A to 16'h9000 (RO) → dev_we=0, bus_err pulse, err_count=1.
REQ-042 SHALL verify: read 16'hE000 (unmapped) → cpu_di=8'hFF, bus_err pulse, no stall.
REQ-043 SHALL verify: 300 unmapped accesses → err_count=8'hFF and holds.
